clk_div_ctrl: RTL

//  Run-time controller for the on-chip divided-clock generator (50 MHz clk).
//  - Owns the divide counter and the square-wave output.
//  - Switches between a fixed table of divide ratios via a req/ack handshake.
//  - Applies every switch only at a falling-edge boundary, so the output never

---
 rtl/clk_div_ctrl_if.sv | 25 ++
 rtl/clk_div_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for the divided-clock generator.
// With CLK_DIV_CTRL_STB_EN defined it also carries the rise_stb strobe.
interface clk_div_ctrl_if;
  logic       enable;
  logic [2:0] sel;
  logic       sel_req;
  logic       sel_ack;
  logic       sel_err;
  logic       busy;
  logic [2:0] cur_sel;
  logic       freq_out;
`ifdef CLK_DIV_CTRL_STB_EN
  logic       rise_stb;

  modport master (output enable, sel, sel_req,
                  input  sel_ack, sel_err, busy, cur_sel, freq_out, rise_stb);
  modport slave  (input  enable, sel, sel_req,
                  output sel_ack, sel_err, busy, cur_sel, freq_out, rise_stb);
`else
  modport master (output enable, sel, sel_req,
                  input  sel_ack, sel_err, busy, cur_sel, freq_out);
  modport slave  (input  enable, sel, sel_req,
                  output sel_ack, sel_err, busy, cur_sel, freq_out);
`endif
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free run-time divided-clock generator with req/ack ratio switching.
// Optional rise_stb output is enabled by defining CLK_DIV_CTRL_STB_EN.
module clk_div_ctrl #(
  parameter int CNT_W       = 5,
  parameter int DIV_DEFAULT = 9
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  function automatic logic [CNT_W-1:0] selToLim(input logic [2:0] s);
    case (s)
      3'd0:    selToLim = CNT_W'(24);
      3'd1:    selToLim = CNT_W'(9);
      3'd2:    selToLim = CNT_W'(8);
      3'd3:    selToLim = CNT_W'(4);
      3'd4:    selToLim = CNT_W'(1);
      default: selToLim = CNT_W'(DIV_DEFAULT);
    endcase
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_lim;
  logic [CNT_W-1:0] r_pendLim;
  logic [2:0]       r_pendSel;
  logic [2:0]       r_curSel;
  logic             r_freq;
  logic             r_busy;
  logic             r_ack;
  logic             r_err;
  logic             r_errFlag;

  logic w_selValid;
  logic w_accept;
  logic w_boundary;
  logic w_apply;

  assign w_selValid = (bus.sel <= 3'd4);
  assign w_accept   = (r_state == S_IDLE) && bus.sel_req;
  assign w_boundary = (r_div == r_lim) && r_freq;
  // A disabled divider has no edge to wait for, so a pending switch lands at once.
  assign w_apply    = (r_state == S_WAIT) && (!bus.enable || w_boundary);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_freq   <= 1'b0;
      r_lim    <= CNT_W'(DIV_DEFAULT);
      r_curSel <= 3'd1;
    end else if (w_apply) begin
      r_div    <= '0;
      r_freq   <= 1'b0;
      r_lim    <= r_pendLim;
      r_curSel <= r_pendSel;
    end else if (!bus.enable) begin
      r_div  <= '0;
      r_freq <= 1'b0;
    end else if (r_div == r_lim) begin
      r_div  <= '0;
      r_freq <= ~r_freq;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Request FSM; busy rises the cycle after acceptance and drops as ack goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_errFlag <= 1'b0;
      r_pendLim <= CNT_W'(DIV_DEFAULT);
      r_pendSel <= 3'd1;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (!w_selValid || (bus.sel == r_curSel)) begin
              r_errFlag <= !w_selValid;
              r_state   <= S_ACK;
            end else begin
              r_errFlag <= 1'b0;
              r_pendSel <= bus.sel;
              r_pendLim <= selToLim(bus.sel);
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_apply) r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= 1'b1;
          r_err   <= r_errFlag;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_STB_EN
  logic r_riseStb;

  // Registered alongside freq_out so the strobe lines up with the 0->1 cycle.
  always_ff @(posedge clk) begin
    if (rst) r_riseStb <= 1'b0;
    else     r_riseStb <= bus.enable && !w_apply && (r_div == r_lim) && !r_freq;
  end

  assign bus.rise_stb = r_riseStb;
`endif

  assign bus.sel_ack  = r_ack;
  assign bus.sel_err  = r_err;
  assign bus.busy     = r_busy;
  assign bus.cur_sel  = r_curSel;
  assign bus.freq_out = r_freq;

endmodule
